// File: rtl/lcd_write_driver.sv
// Character-LCD write port: queues 32-bit command words from the LSU and replays
// them as HD44780-style write cycles (RS/DATA setup, EN pulse, hold, execution wait).
module lcd_write_driver #(
    parameter int FIFO_DEPTH  = 4,
    parameter int T_SETUP     = 2,
    parameter int T_EN_HIGH   = 24,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 1850,
    parameter int T_EXEC_LONG = 76000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_status,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on
);

    localparam int T_MAX_A = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
    localparam int T_MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_EXEC_LONG) ? T_MAX_C : T_EXEC_LONG;
    localparam int CNT_W   = $clog2(T_MAX) + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [2:0]       DEPTH_C      = 3'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LD_SETUP     = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN_HIGH   = CNT_W'(T_EN_HIGH - 1);
    localparam logic [CNT_W-1:0] LD_HOLD      = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC      = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_EXEC
    } state_e;

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]       count_q,  count_d;
    logic             rs_q,     rs_d;
    logic [7:0]       data_q,   data_d;
    logic             en_q,     en_d;
    logic             on_q,     on_d;
    logic             ovf_q,    ovf_d;

    logic [8:0]       fifo_mem_q [FIFO_DEPTH];

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             long_cmd;
    logic             busy;
    logic             unused_wdata;

    assign unused_wdata = ^{i_wdata[29:10], i_wdata[8]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Fullness uses the registered count, so a write on a pop edge still sees full.
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == 3'd0);
    assign push       = i_wr && !i_wdata[30] && !fifo_full;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign long_cmd   = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        on_d  = on_q;
        ovf_d = ovf_q;
        if (i_wr) begin
            on_d = i_wdata[31];
            if (i_wdata[30]) begin
                ovf_d = 1'b0;
            end else if (fifo_full) begin
                ovf_d = 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    rs_d    = fifo_mem_q[rd_ptr_q][8];
                    data_d  = fifo_mem_q[rd_ptr_q][7:0];
                    cnt_d   = LD_SETUP;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = LD_EN_HIGH;
                    state_d = ST_EN_HI;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EN_HI: begin
                if (cnt_q == '0) begin
                    cnt_d   = LD_HOLD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = long_cmd ? LD_EXEC_LONG : LD_EXEC;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        en_d = (state_d == ST_EN_HI);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rs_q     <= 1'b0;
            data_q   <= '0;
            en_q     <= 1'b0;
            on_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            en_q     <= en_d;
            on_q     <= on_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: queue storage is not reset; an entry is only read after count marks it valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {i_wdata[9], i_wdata[7:0]};
        end
    end

    assign o_status   = {on_q, ovf_q, 24'd0, busy, fifo_full, fifo_empty, count_q};
    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;

endmodule

// File: tb/tb_lcd_write_driver.sv
// Bench for lcd_write_driver: directed scenarios plus random traffic, compared
// every cycle against a timeline model of the LCD write protocol.
module tb_lcd_write_driver;

    localparam int DEPTH = 4;
    localparam int TS    = 2;
    localparam int TE    = 4;
    localparam int TH    = 2;
    localparam int TX    = 10;
    localparam int TXL   = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] o_status;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;

    always #5 clk = ~clk;

    lcd_write_driver #(
        .FIFO_DEPTH (DEPTH),
        .T_SETUP    (TS),
        .T_EN_HIGH  (TE),
        .T_HOLD     (TH),
        .T_EXEC     (TX),
        .T_EXEC_LONG(TXL)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_wr      (wr),
        .i_wdata   (wdata),
        .o_status  (o_status),
        .o_lcd_data(o_lcd_data),
        .o_lcd_rs  (o_lcd_rs),
        .o_lcd_rw  (o_lcd_rw),
        .o_lcd_en  (o_lcd_en),
        .o_lcd_on  (o_lcd_on)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Timeline model: each pop at edge n schedules EN high over edges [n+TS, n+TS+TE)
    // and frees the engine for the next pop at edge n+TS+TE+TH+exec+1.
    logic [8:0] mq[$];
    int         cyc       = 0;
    int         next_pop  = 0;
    int         en_rise   = 0;
    int         en_fall   = 0;
    int         idle_from = 0;
    int         pre;
    int         exec_len;
    bit         do_pop;
    logic [8:0] head;
    logic       m_on   = 1'b0;
    logic       m_ovf  = 1'b0;
    logic       m_rs   = 1'b0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            m_on = 1'b0; m_ovf = 1'b0; m_rs = 1'b0; m_data = 8'h00;
            next_pop = 0; en_rise = 0; en_fall = 0; idle_from = 0;
        end else begin
            pre    = mq.size();
            do_pop = (cyc >= next_pop) && (pre > 0);
            if (do_pop) head = mq.pop_front();
            if (wr) begin
                m_on = wdata[31];
                if (wdata[30])        m_ovf = 1'b0;
                else if (pre < DEPTH) mq.push_back({wdata[9], wdata[7:0]});
                else                  m_ovf = 1'b1;
            end
            if (do_pop) begin
                m_rs      = head[8];
                m_data    = head[7:0];
                exec_len  = (!head[8] && (head[7:0] inside {8'h01, 8'h02, 8'h03})) ? TXL : TX;
                en_rise   = cyc + TS;
                en_fall   = en_rise + TE;
                next_pop  = cyc + TS + TE + TH + exec_len + 1;
                idle_from = next_pop - 1;
            end
        end
    end

    bit         chk_en = 1'b0;
    logic [2:0] sz3;
    logic       busy_exp;

    always @(negedge clk) begin
        if (chk_en) begin
            sz3      = 3'(mq.size());
            busy_exp = (cyc < idle_from) || (mq.size() != 0);
            check("lcd_en",   32'(o_lcd_en),   32'((cyc >= en_rise) && (cyc < en_fall)));
            check("lcd_rs",   32'(o_lcd_rs),   32'(m_rs));
            check("lcd_data", 32'(o_lcd_data), 32'(m_data));
            check("lcd_rw",   32'(o_lcd_rw),   32'd0);
            check("lcd_on",   32'(o_lcd_on),   32'(m_on));
            check("status",   o_status,
                  {m_on, m_ovf, 24'd0, busy_exp, sz3 == 3'(DEPTH), sz3 == 3'd0, sz3});
        end
    end

    // Log of {rs,data} and edge number at every EN rise.
    logic       en_prev = 1'b0;
    logic [8:0] obs[$];
    int         obs_t[$];
    logic [8:0] exp_q[$];

    always @(negedge clk) begin
        if (o_lcd_en === 1'b1 && en_prev !== 1'b1) begin
            obs.push_back({o_lcd_rs, o_lcd_data});
            obs_t.push_back(cyc);
        end
        en_prev = o_lcd_en;
    end

    task automatic clear_log();
        obs.delete();
        obs_t.delete();
        exp_q.delete();
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            check(tag, 32'(obs[i]), 32'(exp_q[i]));
    endtask

    task automatic wr_word(input logic [31:0] w);
        wr    = 1'b1;
        wdata = w;
        @(negedge clk);
        wr    = 1'b0;
        wdata = '0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (o_status[5] === 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_not_full(input int bound);
        int n = 0;
        while (o_status[4] === 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) check("wait_full_timeout", 32'd1, 32'd0);
    endtask

    int          k;
    int          t_idle;
    int          r;
    int          n_wait;
    logic [31:0] w;

    initial begin
        rst = 1'b1; wr = 1'b0; wdata = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_status", o_status, 32'h0000_0008);

        // Single data write
        clear_log();
        wr_word(32'h8000_0241);
        k = cyc;
        check("on_after_wr", 32'(o_lcd_on), 32'd1);
        wait_idle(200);
        t_idle = cyc;
        check("busy_len", 32'(t_idle - k), 32'(TS + TE + TH + TX + 1));
        exp_q.push_back(9'h141);
        check_seq("single_seq");
        if (obs_t.size() > 0) check("en_rise_lat", 32'(obs_t[0] - k), 32'(1 + TS));

        // Reset in the middle of an EN pulse, with entries still queued
        clear_log();
        wr_word(32'h8000_0255);
        wr_word(32'h8000_0266);
        wr_word(32'h8000_0277);
        n_wait = 0;
        while (o_lcd_en !== 1'b1 && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        if (n_wait >= 20) check("en_wait_timeout", 32'd1, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_en", 32'(o_lcd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_status2", o_status, 32'h0000_0008);
        check("rst_bus", 32'({o_lcd_rs, o_lcd_data}), 32'd0);
        check("rst_on", 32'(o_lcd_on), 32'd0);
        obs.delete();
        repeat (40) @(negedge clk);
        check("rst_flush", 32'(obs.size()), 32'd0);

        // Long command followed by a normal entry
        clear_log();
        wr_word(32'h0000_0001);
        wr_word(32'h0000_0238);
        wait_idle(400);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h138);
        check_seq("long_seq");
        if (obs_t.size() == 2) check("long_gap", 32'(obs_t[1] - obs_t[0]), 32'(TS + TE + TH + TXL + 1));

        // Six back-to-back writes: one popped early, four queued, one dropped
        clear_log();
        for (int i = 0; i < 6; i++) wr_word(32'h0000_02A0 + 32'(i));
        check("ovf_set", 32'(o_status[30]), 32'd1);
        check("ovf_count", 32'(o_status[2:0]), 32'd4);
        wr_word(32'h4000_0000);
        check("ovf_clr", 32'(o_status[30]), 32'd0);
        check("ovf_clr_count", 32'(o_status[2:0]), 32'd4);
        wait_idle(600);
        for (int i = 0; i < 5; i++) exp_q.push_back(9'h1A0 + 9'(i));
        check_seq("ovf_seq");

        // Wrap-around streaming, paced on the full flag
        clear_log();
        for (int i = 0; i < 10; i++) begin
            wait_not_full(200);
            wr_word(32'h0000_0230 + 32'(i));
        end
        wait_idle(600);
        for (int i = 0; i < 10; i++) exp_q.push_back(9'h130 + 9'(i));
        check_seq("wrap_seq");

        // Write while full, landing on the IDLE pop edge
        clear_log();
        wr_word(32'h0000_02B0);
        k = cyc;
        for (int i = 1; i < 5; i++) wr_word(32'h0000_02B0 + 32'(i));
        check("fullpop_pre_count", 32'(o_status[2:0]), 32'd4);
        while (cyc < k + TS + TE + TH + TX + 1) @(negedge clk);
        wr_word(32'h0000_02BF);
        check("fullpop_ovf", 32'(o_status[30]), 32'd1);
        check("fullpop_count", 32'(o_status[2:0]), 32'd3);
        wait_idle(600);
        for (int i = 0; i < 5; i++) exp_q.push_back(9'h1B0 + 9'(i));
        check_seq("fullpop_seq");

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else if (r < 30) begin
                w     = $urandom();
                w[30] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    w[9]   = 1'b0;
                    w[7:0] = 8'($urandom_range(1, 3));
                end
                wr_word(w);
            end else begin
                @(negedge clk);
            end
        end
        wait_idle(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
